// File: rtl/process_element_pkg.sv
// Shared definitions for the process-element datapath stages.
//   - Default widths for the product / accumulator / output paths.
//   - FSM state encoding for window accumulation.
//   - sat_add and requant helpers, also used by the bias stage.
// Helpers work on 64-bit signed values with a runtime width argument; with
// constant width arguments they reduce to plain compare/select logic.
package process_element_pkg;

    localparam int PROD_W_DEF = 23;
    localparam int ACC_W_DEF  = 32;
    localparam int OUT_W_DEF  = 8;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    // Value plus a flag that is set when the value had to be clipped.
    typedef struct packed {
        logic signed [63:0] value;
        logic               flag;
    } clip_result_t;

    // Clamp v into the signed range of a w-bit number.
    function automatic clip_result_t clamp_signed(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        clip_result_t       res;
        hi        = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo        = -hi - 64'sd1;
        res.value = v;
        res.flag  = 1'b0;
        if (v > hi) begin
            res.value = hi;
            res.flag  = 1'b1;
        end else if (v < lo) begin
            res.value = lo;
            res.flag  = 1'b1;
        end
        return res;
    endfunction

    // Saturating add into a w-bit signed accumulator.
    function automatic clip_result_t sat_add(input logic signed [63:0] a,
                                             input logic signed [63:0] b,
                                             input int w);
        return clamp_signed(a + b, w);
    endfunction

    // Round-half-up, arithmetic shift, optional ReLU, saturate to out_w bits.
    // The 64-bit intermediate never wraps for ACC_W up to 62.
    function automatic clip_result_t requant(input logic signed [63:0] s,
                                             input int shift,
                                             input int out_w,
                                             input logic relu);
        logic signed [63:0] r;
        r = s;
        if (shift > 0) begin
            r = r + (64'sd1 <<< (shift - 1));
        end
        r = r >>> shift;
        if (relu && (r < 64'sd0)) begin
            r = 64'sd0;
        end
        return clamp_signed(r, out_w);
    endfunction

endpackage

// File: rtl/process_element_requant.sv
// Combinational requantizer: accumulator sum -> signed OUT_W result.
//   sum      in   ACC_W  signed accumulator value
//   data     out  OUT_W  rounded, shifted, optionally ReLU'd, saturated result
//   clamped  out  1      result was saturated to the OUT_W range
module process_element_requant
    import process_element_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int SHIFT = 8,
    parameter int OUT_W = OUT_W_DEF,
    parameter int RELU  = 0
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic        [OUT_W-1:0] data,
    output logic                    clamped
);

    clip_result_t res;

    always_comb begin
        res     = requant(64'(sum), SHIFT, OUT_W, RELU != 0);
        data    = res.value[OUT_W-1:0];
        clamped = res.flag;
    end

endmodule

// File: rtl/process_element_acc_requant.sv
// Window accumulator + requantizer behind the PE multiplier.
// Sums signed products until in_last, then presents one int8-style result
// on a valid/ready output; input is stalled while a result is pending.
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     product beat handshake (in_ready high only in ACCUM)
//   in_data, in_last      signed product, final beat of window
//   out_valid/out_ready   result handshake
//   out_data              signed requantized result
//   out_ovf               accumulator or output saturated in this window
//   out_beats             beats in window, modulo 2^CNT_W
module process_element_acc_requant
    import process_element_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SHIFT  = 8,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int RELU   = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  out_beats
);

    state_t state, state_nxt;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic                    first;
    logic [CNT_W-1:0]        beats;
    logic                    ovf;
    logic                    ovf_nxt;
    clip_result_t            add_res;
    logic [OUT_W-1:0]        rq_data;
    logic                    rq_clamped;

    logic accept;
    logic done;

    assign accept = in_valid && in_ready;
    assign done   = out_valid && out_ready;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) state <= ACCUM;
        else       state <= state_nxt;
    end

    // Next-state logic.
    // NOTE: default assignment first, so no path leaves state_nxt unassigned
    // and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && in_last) state_nxt = OUTPUT;
            OUTPUT:  if (done)              state_nxt = ACCUM;
            default:                        state_nxt = ACCUM;
        endcase
    end

    // Handshake outputs are pure state decodes: no out_ready -> in_ready path.
    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == OUTPUT);
    end

    // First beat of a window adds to zero; with ACC_W > PROD_W that cannot
    // clip, so the ovf flag only starts accumulating from the second beat.
    always_comb begin
        add_res = sat_add(first ? 64'sd0 : 64'(acc), 64'($signed(in_data)), ACC_W);
        acc_nxt = add_res.value[ACC_W-1:0];
        ovf_nxt = (ovf && !first) || add_res.flag;
    end

    // Requant operates on the post-add value so the result is ready to be
    // registered in the same cycle the last beat is accepted.
    process_element_requant #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W),
        .RELU  (RELU)
    ) u_requant (
        .sum     (acc_nxt),
        .data    (rq_data),
        .clamped (rq_clamped)
    );

    // Accumulator, beat counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            first     <= 1'b1;
            beats     <= '0;
            ovf       <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_beats <= '0;
        end else if (accept) begin
            acc   <= acc_nxt;
            first <= 1'b0;
            beats <= beats + 1'b1;
            ovf   <= ovf_nxt;
            if (in_last) begin
                out_data  <= rq_data;
                out_ovf   <= ovf_nxt || rq_clamped;
                out_beats <= beats + 1'b1;
            end
        end else if (done) begin
            first <= 1'b1;
            beats <= '0;
            ovf   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_process_element_acc_requant.sv
// Directed bench for process_element_acc_requant.
// Four instances cover the parameter points of interest:
//   0: ACC_W=32 SHIFT=4  RELU=0   1: ACC_W=24 SHIFT=16 RELU=0
//   2: ACC_W=32 SHIFT=4  RELU=1   3: ACC_W=32 SHIFT=0  RELU=0
module tb_process_element_acc_requant;

    localparam int N     = 4;
    localparam int LIMIT = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid  [N];
    logic        in_ready  [N];
    logic [22:0] in_data   [N];
    logic        in_last   [N];
    logic        out_valid [N];
    logic        out_ready [N];
    logic [7:0]  out_data  [N];
    logic        out_ovf   [N];
    logic [15:0] out_beats [N];

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    process_element_acc_requant #(.PROD_W(23), .ACC_W(32), .SHIFT(4), .OUT_W(8), .RELU(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_last(in_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_ovf(out_ovf[0]), .out_beats(out_beats[0]));

    process_element_acc_requant #(.PROD_W(23), .ACC_W(24), .SHIFT(16), .OUT_W(8), .RELU(0), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_last(in_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_ovf(out_ovf[1]), .out_beats(out_beats[1]));

    process_element_acc_requant #(.PROD_W(23), .ACC_W(32), .SHIFT(4), .OUT_W(8), .RELU(1), .CNT_W(16)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .in_last(in_last[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .out_ovf(out_ovf[2]), .out_beats(out_beats[2]));

    process_element_acc_requant #(.PROD_W(23), .ACC_W(32), .SHIFT(0), .OUT_W(8), .RELU(0), .CNT_W(16)) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data[3]),
        .in_last(in_last[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(out_data[3]),
        .out_ovf(out_ovf[3]), .out_beats(out_beats[3]));

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // All tasks start and end at #1 after a rising edge.
    task automatic send_beat(input int i, input longint d, input logic last);
        int n = 0;
        in_valid[i] = 1'b1;
        in_data[i]  = d[22:0];
        in_last[i]  = last;
        while (!in_ready[i] && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_timeout", longint'(n < LIMIT), 1);
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
    endtask

    task automatic expect_result(input int i, input string tag,
                                 input longint d, input longint ovf, input longint beats);
        int n = 0;
        while (!out_valid[i] && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_valid"}, longint'(out_valid[i]), 1);
        check({tag, "_data"},  longint'($signed(out_data[i])), d);
        check({tag, "_ovf"},   longint'(out_ovf[i]), ovf);
        check({tag, "_beats"}, longint'(out_beats[i]), beats);
        out_ready[i] = 1'b1;
        @(posedge clk); #1;
        out_ready[i] = 1'b0;
    endtask

    initial begin
        logic [7:0] held;
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_valid[i] = 1'b0; in_data[i] = '0; in_last[i] = 1'b0; out_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  longint'(in_ready[0]), 1);
        check("rst_out_valid", longint'(out_valid[0]), 0);
        check("rst_out_data",  longint'(out_data[0]), 0);
        check("rst_out_ovf",   longint'(out_ovf[0]), 0);
        check("rst_out_beats", longint'(out_beats[0]), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 100 + 200 - 50 = 250; (250+8)>>>4 = 16; valid right after last beat.
        send_beat(0, 100, 1'b0);
        send_beat(0, 200, 1'b0);
        send_beat(0, -50, 1'b1);
        check("w3_latency", longint'(out_valid[0]), 1);
        expect_result(0, "w3", 16, 0, 3);

        // Rounding of single-beat windows at SHIFT=4.
        send_beat(0, 24, 1'b1);       expect_result(0, "rnd_p24", 2, 0, 1);
        send_beat(0, -24, 1'b1);      expect_result(0, "rnd_m24", -1, 0, 1);
        send_beat(0, 7, 1'b1);        expect_result(0, "rnd_p7", 0, 0, 1);
        send_beat(0, 8, 1'b1);        expect_result(0, "rnd_p8", 1, 0, 1);

        // Output saturation.
        send_beat(0, 4194303, 1'b1);  expect_result(0, "sat_pos", 127, 1, 1);
        send_beat(0, -4194304, 1'b1); expect_result(0, "sat_neg", -128, 1, 1);

        // ACC_W=24: third beat clips the accumulator at 8388607.
        send_beat(1, 4194303, 1'b0);
        send_beat(1, 4194303, 1'b0);
        send_beat(1, 4194303, 1'b1);
        expect_result(1, "acc_clip", 127, 1, 3);

        // Backpressure: (1000+8)>>>4 = 63 held while the next beat waits.
        send_beat(0, 1000, 1'b1);
        in_valid[0] = 1'b1; in_data[0] = 23'd32; in_last[0] = 1'b1;
        held = out_data[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid",    longint'(out_valid[0]), 1);
            check("bp_data",     longint'($signed(out_data[0])), 63);
            check("bp_stable",   longint'(out_data[0]), longint'(held));
            check("bp_in_ready", longint'(in_ready[0]), 0);
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        check("bp_after_valid", longint'(out_valid[0]), 0);
        check("bp_after_ready", longint'(in_ready[0]), 1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0; in_last[0] = 1'b0;
        // Fresh window: (32+8)>>>4 = 2, one beat.
        expect_result(0, "bp_next", 2, 0, 1);

        // ReLU: (-500+8)>>>4 = -31 -> 0, not a saturation.
        send_beat(2, -500, 1'b1);
        expect_result(2, "relu", 0, 0, 1);

        // Reset on the second beat of a window discards it.
        send_beat(3, 50, 1'b0);
        in_valid[3] = 1'b1; in_data[3] = 23'd60; in_last[3] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid[3] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_valid", longint'(out_valid[3]), 0);
        check("rst_mid_ready", longint'(in_ready[3]), 1);
        send_beat(3, 10, 1'b1);
        expect_result(3, "after_rst", 10, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
